// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control for F/D and D/E1 (load-use, mul/div busy, taken branch).
// Latency: stall/flush outputs are combinational; MulDivBusy is registered (asserts the cycle after start).
// Backpressure: StallF/StallD hold the front end and FlushE1 bubbles E1; optional perf counters with HAZARD_PERF_EN.
module hazard_unit #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       MemReadE1,
    input  logic       MemReadE2,
    input  logic [4:0] RAddrE1,
    input  logic [4:0] RAddrE2,
    input  logic [4:0] RsAddrD,
    input  logic [4:0] RtAddrD,
    input  logic       UsesRsD,
    input  logic       UsesRtD,
    input  logic       MulDivStartE1,
    input  logic       MulDivUseD,
    input  logic       BranchTakenE1,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE1,
    output logic       MulDivBusy,
    output logic       MulDivDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCycles,
    output logic [15:0] FlushCount
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_d;

    logic lu_e1, lu_e2, lu, mdh;

    // A load in E1 or E2 whose destination is a live, non-zero source of D
    // cannot be forwarded yet: the data only appears from M onward.
    always_comb begin
        lu_e1 = MemReadE1 && (RAddrE1 != 5'd0) &&
                ((UsesRsD && (RAddrE1 == RsAddrD)) || (UsesRtD && (RAddrE1 == RtAddrD)));
        lu_e2 = MemReadE2 && (RAddrE2 != 5'd0) &&
                ((UsesRsD && (RAddrE2 == RsAddrD)) || (UsesRtD && (RAddrE2 == RtAddrD)));
        lu    = lu_e1 || lu_e2;
        // The start cycle counts too: the unit is committed even before Busy rises.
        mdh   = MulDivUseD && ((state_q == BUSY) || MulDivStartE1);
    end

    // Mul/div busy window: next state, counter and the last-cycle pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (MulDivStartE1) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            BUSY: begin
                // A start pulse here is a protocol violation and is ignored.
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Mul/div state register; reset aborts any window in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush beats stall: a taken branch discards D, so D's hazard no longer matters.
    // Outputs are held low while reset is asserted.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        FlushE1 = 1'b0;
        if (nReset) begin
            if (BranchTakenE1) begin
                FlushD = 1'b1;
            end else if (lu || mdh) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE1 = 1'b1;
            end
        end
    end

    assign MulDivBusy = (state_q == BUSY);
    assign MulDivDone = done_d;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cyc_q;
    logic [15:0] flush_cnt_q;

    // Stall cycles wrap; flush count saturates so it never misreports as small.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
            if (FlushD && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign StallCycles = stall_cyc_q;
    assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: two hazard_unit instances (4-cycle and 32-cycle mul/div) on shared inputs.
// Outputs checked every negedge against a behavioural model (busy-cycles-remaining counters).
// Directed scenarios add literal expectations, then randomized traffic runs.
module tb_hazard_unit;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       MemReadE1, MemReadE2;
    logic [4:0] RAddrE1, RAddrE2, RsAddrD, RtAddrD;
    logic       UsesRsD, UsesRtD, MulDivStartE1, MulDivUseD, BranchTakenE1;

    logic [1:0] StallF_o, StallD_o, FlushD_o, FlushE1_o, Busy_o, Done_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles_o [2];
    logic [15:0] FlushCount_o  [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 Clock = ~Clock;

    hazard_unit #(.MULDIV_CYCLES(4), .CNT_W(6)) u4 (
        .Clock(Clock), .nReset(nReset),
        .MemReadE1(MemReadE1), .MemReadE2(MemReadE2),
        .RAddrE1(RAddrE1), .RAddrE2(RAddrE2), .RsAddrD(RsAddrD), .RtAddrD(RtAddrD),
        .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
        .MulDivStartE1(MulDivStartE1), .MulDivUseD(MulDivUseD), .BranchTakenE1(BranchTakenE1),
        .StallF(StallF_o[0]), .StallD(StallD_o[0]), .FlushD(FlushD_o[0]), .FlushE1(FlushE1_o[0]),
        .MulDivBusy(Busy_o[0]), .MulDivDone(Done_o[0])
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles_o[0]), .FlushCount(FlushCount_o[0])
`endif
    );

    hazard_unit #(.MULDIV_CYCLES(32), .CNT_W(6)) u32 (
        .Clock(Clock), .nReset(nReset),
        .MemReadE1(MemReadE1), .MemReadE2(MemReadE2),
        .RAddrE1(RAddrE1), .RAddrE2(RAddrE2), .RsAddrD(RsAddrD), .RtAddrD(RtAddrD),
        .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
        .MulDivStartE1(MulDivStartE1), .MulDivUseD(MulDivUseD), .BranchTakenE1(BranchTakenE1),
        .StallF(StallF_o[1]), .StallD(StallD_o[1]), .FlushD(FlushD_o[1]), .FlushE1(FlushE1_o[1]),
        .MulDivBusy(Busy_o[1]), .MulDivDone(Done_o[1])
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles_o[1]), .FlushCount(FlushCount_o[1])
`endif
    );

    // ---------------- behavioural model ----------------
    int ncyc [2] = '{4, 32};
    int busy_left [2];          // busy cycles still to come, including the current one
    logic [31:0] sc_m [2];
    int          fc_m [2];

    function automatic logic dep(input logic rd, input logic [4:0] a);
        return rd && (a != 5'd0) && ((UsesRsD && a == RsAddrD) || (UsesRtD && a == RtAddrD));
    endfunction

    // {StallF, StallD, FlushD, FlushE1, Busy, Done}
    function automatic logic [5:0] expv(input int k);
        logic busy, done, hz;
        busy = busy_left[k] > 0;
        done = busy_left[k] == 1;
        hz   = dep(MemReadE1, RAddrE1) || dep(MemReadE2, RAddrE2) ||
               (MulDivUseD && (busy || MulDivStartE1));
        if (BranchTakenE1) return {4'b0010, busy, done};
        else if (hz)       return {4'b1101, busy, done};
        else               return {4'b0000, busy, done};
    endfunction

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < 2; k++) begin
                busy_left[k] = 0;
                sc_m[k] = 0;
                fc_m[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [5:0] e;
                e = expv(k);
                if (e[4]) sc_m[k] = sc_m[k] + 32'd1;
                if (e[3] && fc_m[k] < 65535) fc_m[k]++;
                if (busy_left[k] > 0) busy_left[k]--;
                else if (MulDivStartE1) busy_left[k] = ncyc[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge Clock) begin
        if (nReset && chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [5:0] e;
                string p;
                e = expv(k);
                p = (k == 0) ? "md4" : "md32";
                chk({p, ".StallF"},     32'(StallF_o[k]),  32'(e[5]));
                chk({p, ".StallD"},     32'(StallD_o[k]),  32'(e[4]));
                chk({p, ".FlushD"},     32'(FlushD_o[k]),  32'(e[3]));
                chk({p, ".FlushE1"},    32'(FlushE1_o[k]), 32'(e[2]));
                chk({p, ".MulDivBusy"}, 32'(Busy_o[k]),    32'(e[1]));
                chk({p, ".MulDivDone"}, 32'(Done_o[k]),    32'(e[0]));
`ifdef HAZARD_PERF_EN
                chk({p, ".StallCycles"}, StallCycles_o[k], sc_m[k]);
                chk({p, ".FlushCount"},  32'(FlushCount_o[k]), 32'(fc_m[k]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        MemReadE1 = 0; MemReadE2 = 0; RAddrE1 = 0; RAddrE2 = 0; RsAddrD = 0; RtAddrD = 0;
        UsesRsD = 0; UsesRtD = 0; MulDivStartE1 = 0; MulDivUseD = 0; BranchTakenE1 = 0;
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    int done_seen;

    initial begin
        clr();
        nReset = 1'b0;
        #1;
        chk("rst.StallD", 32'(StallD_o), 32'd0);
        chk("rst.Busy",   32'(Busy_o),   32'd0);
        chk("rst.Done",   32'(Done_o),   32'd0);
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;
        chk_en = 1'b1;

        // Load-use: load $5 in E1, then E2; D reads rs=$5.
        MemReadE1 = 1; RAddrE1 = 5; RsAddrD = 5; UsesRsD = 1;
        @(negedge Clock); chk("lu.c1.StallD", 32'(StallD_o), 32'b11);
        chk("lu.c1.FlushE1", 32'(FlushE1_o), 32'b11);
        next();
        MemReadE1 = 0; RAddrE1 = 0; MemReadE2 = 1; RAddrE2 = 5;
        @(negedge Clock); chk("lu.c2.StallF", 32'(StallF_o), 32'b11);
        next();
        MemReadE2 = 0; RAddrE2 = 0;
        @(negedge Clock); chk("lu.c3.StallD", 32'(StallD_o), 32'b00);
        next();

        // Register 0 and unused rt never stall.
        MemReadE1 = 1; RAddrE1 = 0; RsAddrD = 0; UsesRsD = 1;
        @(negedge Clock); chk("r0.StallD", 32'(StallD_o), 32'b00);
        next();
        RAddrE1 = 7; RtAddrD = 7; UsesRsD = 0; UsesRtD = 0; RsAddrD = 3;
        @(negedge Clock); chk("unused_rt.StallD", 32'(StallD_o), 32'b00);
        next();
        clr();

        // Mul/div window on the 4-cycle instance.
        MulDivStartE1 = 1;
        @(negedge Clock); chk("md.t.StallD", 32'(StallD_o[0]), 32'd0);
        chk("md.t.Busy", 32'(Busy_o[0]), 32'd0);
        next();
        MulDivStartE1 = 0; MulDivUseD = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clock);
            chk($sformatf("md.t+%0d.Busy", i),   32'(Busy_o[0]),   32'd1);
            chk($sformatf("md.t+%0d.StallD", i), 32'(StallD_o[0]), 32'd1);
            chk($sformatf("md.t+%0d.Done", i),   32'(Done_o[0]),   32'(i == 4));
            next();
        end
        @(negedge Clock); chk("md.t+5.StallD", 32'(StallD_o[0]), 32'd0);
        chk("md.t+5.Busy", 32'(Busy_o[0]), 32'd0);
        next();
        MulDivUseD = 0;

        chk("model.sc4", sc_m[0], 32'd6);
        chk("model.fc4", 32'(fc_m[0]), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("perf.StallCycles", StallCycles_o[0], 32'd6);
        chk("perf.FlushCount",  32'(FlushCount_o[0]), 32'd0);
`endif

        // Branch wins over a live load-use.
        MemReadE1 = 1; RAddrE1 = 5; RsAddrD = 5; UsesRsD = 1; BranchTakenE1 = 1;
        @(negedge Clock);
        chk("br.FlushD",  32'(FlushD_o[0]),  32'd1);
        chk("br.StallF",  32'(StallF_o[0]),  32'd0);
        chk("br.StallD",  32'(StallD_o[0]),  32'd0);
        chk("br.FlushE1", 32'(FlushE1_o[0]), 32'd0);
        next();
        clr();
        @(negedge Clock); chk("br.after.FlushD", 32'(FlushD_o), 32'd0);
        next();

        // Reset mid-count on the 32-cycle instance at busy cycle 10.
        nReset = 1'b0; #1 nReset = 1'b1;
        next();
        MulDivStartE1 = 1;
        next();
        MulDivStartE1 = 0;
        repeat (9) next();
        chk("rmc.before.Busy32", 32'(Busy_o[1]), 32'd1);
        MemReadE1 = 1; RAddrE1 = 5; RsAddrD = 5; UsesRsD = 1;
        #2 nReset = 1'b0;
        #1;
        chk("rmc.async.Busy32", 32'(Busy_o[1]), 32'd0);
        chk("rmc.async.StallD", 32'(StallD_o), 32'd0);
        @(posedge Clock);
        #2 nReset = 1'b1;
        clr();
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done_o[1]) done_seen++;
            next();
        end
        chk("rmc.no_done", 32'(done_seen), 32'd0);
        chk("rmc.idle.Busy32", 32'(Busy_o[1]), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            MemReadE1     = ($urandom_range(0, 2) == 0);
            MemReadE2     = ($urandom_range(0, 2) == 0);
            RAddrE1       = 5'($urandom_range(0, 3));
            RAddrE2       = 5'($urandom_range(0, 3));
            RsAddrD       = 5'($urandom_range(0, 3));
            RtAddrD       = 5'($urandom_range(0, 3));
            UsesRsD       = 1'($urandom_range(0, 1));
            UsesRtD       = 1'($urandom_range(0, 1));
            MulDivStartE1 = ($urandom_range(0, 11) == 0);
            MulDivUseD    = ($urandom_range(0, 2) == 0);
            BranchTakenE1 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                nReset = 1'b0; #1 nReset = 1'b1;
            end
            next();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
